mac_accumulator: RTL and testbench
==================================

MAC_ACCUMULATOR -- requirements
Module: mac_accumulator

Interface
REQ-001 SHALL have parameter PROD_W, default 64, the width of the unsigned product consumed from the vedic multiplier array.
REQ-002 SHALL have parameter LEN, default 4, the number of products per dot product; legal range 2..256.
REQ-003 SHALL have parameter ACC_W, default PROD_W+$clog2(LEN), the width of the sum.
REQ-004 SHALL have one clock and a synchronous, active-high reset: clk and rst.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 in_product  input  PROD_W  unsigned product from the multiplier.
REQ-008 in_valid  input  1  in_product is valid this cycle.
REQ-009 in_ready  output  1  block accepts in_product this cycle.
REQ-010 flush  input  1  abandons the partial dot product.
REQ-011 out_sum  output  ACC_W  completed dot-product sum.
REQ-012 out_valid  output  1  out_sum is valid.
REQ-013 out_ready  input  1  consumer takes out_sum.
REQ-014 count  output  $clog2(LEN)  number of products accumulated in the current vector.

Function
REQ-015 An input is accepted when in_valid & in_ready at a clk edge; an output is taken when out_valid & out_ready at a clk edge.
REQ-016 The block SHALL hold two implicit states, derived from count and out_valid:
- EMPTY: count=0.
- PARTIAL: 0<count<LEN.
Output occupancy (out_valid) is independent of these states.
REQ-017 On an accept with count<LEN-1, the block SHALL do all of the following:
- acc <= (count==0 ? in_product : acc+in_product), zero-extended to ACC_W.
- count <= count+1.
REQ-018 On an accept with count=LEN-1, the block SHALL do all of the following:
- out_sum <= acc+in_product.
- out_valid <= 1.
- count <= 0.
Latency from the final accept to out_valid is one cycle.
REQ-019 in_ready SHALL be !rst & !flush & !(count==LEN-1 & out_valid & !out_ready). This is combinational from out_ready, so the previous sum is replaced in the same cycle it is taken.
REQ-020 Accumulation of the next vector SHALL continue while out_valid is high; only the completing element stalls.
REQ-021 A taken output with no simultaneous completion SHALL clear out_valid. A take together with a completion SHALL leave out_valid at 1 with the new sum.
REQ-022 out_sum and out_valid SHALL stay stable while out_valid & !out_ready.
REQ-023 flush SHALL set count to 0 and discard acc. It has no effect on out_sum or out_valid. During flush, in_ready is 0 and no input is accepted.
REQ-024 Sums SHALL be unsigned with no overflow; ACC_W guarantees LEN maximal products fit.
REQ-025 An input presented while in_ready=0 SHALL NOT alter any state.

Reset
REQ-026 With rst high at a clk edge, the block SHALL set count=0, acc=0, out_sum=0 and out_valid=0, overriding every simultaneous event.
REQ-027 With rst asserted mid-vector, the block SHALL discard the partial sum; the first accept after rst starts a new vector.
REQ-028 in_ready SHALL be 0 in any cycle with rst high.

Structure
REQ-029 The default PROD_W, LEN and ACC_W values and the count width function SHALL live in the shared package mac_pkg.
REQ-030 The output register with its valid/ready hold logic SHALL be one sub-module, sum_hold_reg.
REQ-031 The block SHALL NOT use asynchronous logic, latches or multicycle paths.

Verification (LEN=4, PROD_W=64)
REQ-032 Basic vector:
- Stimulus: out_ready=1; products 1,2,3,4 on back-to-back cycles.
- Response: out_sum=10 with out_valid for exactly one cycle, one cycle after the 4th accept.
REQ-033 Maximum values:
- Stimulus: four products of 2^64-1.
- Response: out_sum=4*(2^64-1)=0x3_FFFF_FFFF_FFFF_FFFC, no truncation.
REQ-034 Backpressure:
- Stimulus: out_ready=0; vectors {1,1,1,1} then {2,2,2,2}.
- Response: out_sum holds 4; the 2nd vector's 4th element sees in_ready=0; after out_ready=1 in that cycle, out_sum=8 on the next cycle.
REQ-035 Flush:
- Stimulus: accept 5,6; flush for one cycle with in_valid=1 and product 9; then 1,1,1,1.
- Response: 9 is not accepted; out_sum=4.
REQ-036 Reset:
- Stimulus: rst after two accepts while out_valid=1.
- Response: out_valid=0, count=0, out_sum=0 next cycle; vector 3,3,3,3 then gives 12.
REQ-037 Random stream:
- Stimulus: 1000 products with random in_valid/out_ready.
- Response: every out_sum equals the reference sum of each group of 4, in order, with none lost or duplicated.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared defaults and sizing helpers for the MAC accumulator.
// Imported by the accumulator top and its output holding register.
package mac_pkg;

  localparam int DEF_PROD_W = 64;
  localparam int DEF_LEN    = 4;

  function automatic int cnt_w(input int len);
    return $clog2(len);
  endfunction

  localparam int DEF_ACC_W = DEF_PROD_W + cnt_w(DEF_LEN);

endpackage

// File: rtl/sum_hold_reg.sv
// Output register for a completed sum with valid/ready hold.
// A load always wins over a take in the same cycle.
module sum_hold_reg
  import mac_pkg::*;
#(
  parameter int W = DEF_ACC_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  input  logic         take_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (valid_q && take_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/mac_accumulator.sv
// Sums LEN unsigned products into one dot-product result.
// Next vector keeps accumulating while the previous sum waits.
module mac_accumulator
  import mac_pkg::*;
#(
  parameter int PROD_W = DEF_PROD_W,
  parameter int LEN    = DEF_LEN,
  parameter int ACC_W  = PROD_W + cnt_w(LEN)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PROD_W-1:0]      in_product,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   flush,
  output logic [ACC_W-1:0]       out_sum,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [cnt_w(LEN)-1:0]  count
);

  localparam int CW = cnt_w(LEN);
  localparam logic [CW-1:0] LAST = CW'(LEN - 1);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] prod_x, sum_x;
  logic             last, accept, complete;

  assign prod_x = ACC_W'(in_product);
  assign sum_x  = acc_q + prod_x;
  assign last   = (cnt_q == LAST);

  // Only the completing element waits on a still-occupied output.
  assign in_ready = !rst && !flush
                 && !(last && out_valid && !out_ready);
  assign accept   = in_valid && in_ready;
  assign complete = accept && last;

  always_comb begin
    cnt_d = cnt_q;
    acc_d = acc_q;
    if (flush) begin
      cnt_d = '0;
      acc_d = '0;
    end else if (accept) begin
      if (last) begin
        cnt_d = '0;
        acc_d = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
        acc_d = (cnt_q == '0) ? prod_x : sum_x;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      acc_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
    end
  end

  sum_hold_reg #(
    .W (ACC_W)
  ) u_hold (
    .clk     (clk),
    .rst     (rst),
    .load_i  (complete),
    .data_i  (sum_x),
    .take_i  (out_ready),
    .valid_o (out_valid),
    .data_o  (out_sum)
  );

  assign count = cnt_q;

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed and random checks of mac_accumulator (LEN=4, PROD_W=64)
// against a transaction model with a sum scoreboard.
module tb_mac_accumulator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] in_product = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        flush = 1'b0;
  logic [65:0] out_sum;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [1:0]  count;

  int errors = 0;
  int checks = 0;

  logic [65:0] q[$];
  int          mcnt = 0;
  logic [65:0] macc = '0;
  bit          mvalid = 1'b0;
  int          naccept = 0;

  mac_accumulator dut (
    .clk        (clk),
    .rst        (rst),
    .in_product (in_product),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .flush      (flush),
    .out_sum    (out_sum),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .count      (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [65:0] got,
                     input logic [65:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input bit v, input logic [63:0] p,
                      input bit rdy, input bit fl, input bit r);
    bit          er, tk, acc;
    logic [65:0] e;
    @(negedge clk);
    in_valid   = v;
    in_product = p;
    out_ready  = rdy;
    flush      = fl;
    rst        = r;
    #1;
    er = !r && !fl && !(mcnt == 3 && mvalid && !rdy);
    chk("in_ready", 66'(in_ready), 66'(er));
    chk("out_valid", 66'(out_valid), 66'(mvalid));
    chk("count", 66'(count), 66'(mcnt));
    tk  = mvalid && rdy;
    acc = v && er;
    if (tk && !r) begin
      chk("sb_size", 66'(q.size()), 66'd1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("out_sum", out_sum, e);
      end
    end
    if (r) begin
      mcnt = 0;
      macc = '0;
      mvalid = 1'b0;
      q.delete();
    end else begin
      if (tk) mvalid = 1'b0;
      if (fl) begin
        mcnt = 0;
        macc = '0;
      end else if (acc) begin
        naccept++;
        if (mcnt == 3) begin
          q.push_back(macc + 66'(p));
          mvalid = 1'b1;
          mcnt = 0;
          macc = '0;
        end else begin
          macc = (mcnt == 0) ? 66'(p) : macc + 66'(p);
          mcnt++;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n0, cyc;
    // reset
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("rst_valid", 66'(out_valid), 66'd0);
    chk("rst_count", 66'(count), 66'd0);
    chk("rst_sum", out_sum, 66'd0);

    // basic vector
    step(1, 1, 1, 0, 0);
    step(1, 2, 1, 0, 0);
    step(1, 3, 1, 0, 0);
    step(1, 4, 1, 0, 0);
    chk("basic_valid", 66'(out_valid), 66'd1);
    chk("basic_sum", out_sum, 66'd10);
    step(0, 0, 1, 0, 0);
    chk("basic_one_cycle", 66'(out_valid), 66'd0);

    // maximum products
    for (int i = 0; i < 4; i++) step(1, '1, 1, 0, 0);
    chk("max_sum", out_sum, 66'h3_FFFF_FFFF_FFFF_FFFC);
    step(0, 0, 1, 0, 0);

    // backpressure
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 0);
    chk("bp_sum4", out_sum, 66'd4);
    for (int i = 0; i < 3; i++) step(1, 2, 0, 0, 0);
    chk("bp_count3", 66'(count), 66'd3);
    step(1, 2, 0, 0, 0);
    chk("bp_hold_sum", out_sum, 66'd4);
    chk("bp_hold_count", 66'(count), 66'd3);
    step(1, 2, 1, 0, 0);
    chk("bp_sum8", out_sum, 66'd8);
    chk("bp_valid", 66'(out_valid), 66'd1);
    step(0, 0, 1, 0, 0);

    // flush
    step(1, 5, 1, 0, 0);
    step(1, 6, 1, 0, 0);
    step(1, 9, 1, 1, 0);
    chk("flush_count", 66'(count), 66'd0);
    for (int i = 0; i < 4; i++) step(1, 1, 1, 0, 0);
    chk("flush_sum", out_sum, 66'd4);
    step(0, 0, 1, 0, 0);

    // reset mid-vector with a pending sum
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 0);
    step(1, 3, 0, 0, 0);
    step(1, 3, 0, 0, 0);
    step(1, 7, 0, 0, 1);
    chk("mid_rst_valid", 66'(out_valid), 66'd0);
    chk("mid_rst_count", 66'(count), 66'd0);
    chk("mid_rst_sum", out_sum, 66'd0);
    for (int i = 0; i < 4; i++) step(1, 3, 1, 0, 0);
    chk("post_rst_sum", out_sum, 66'd12);
    step(0, 0, 1, 0, 0);

    // random stream
    n0 = naccept;
    cyc = 0;
    while ((naccept - n0) < 1000 && cyc < 20000) begin
      step(bit'($urandom_range(0, 1)), {$urandom, $urandom},
           bit'($urandom_range(0, 3) != 0), 0, 0);
      cyc++;
    end
    chk("rand_accepted", 66'(naccept - n0), 66'd1000);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0);
    chk("rand_sb_empty", 66'(q.size()), 66'd0);
    chk("rand_drained", 66'(out_valid), 66'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
